// File: rtl/pc_ctrl_pkg.sv
// Shared types and constants for the front-end PC sequencing controller.
package pc_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_IMISS = 2'd2
  } pc_state_t;

  localparam logic [31:0] PC_INCR              = 32'd4;
  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/pc_ctrl_hazard_detect.sv
// Load-use comparator: a load in EX whose destination feeds an ID source operand.
module hazard_detect (
  input  logic       ex_memread,
  input  logic [4:0] ex_rd,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  output logic       load_use
);

  // x0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign load_use = ex_memread && (ex_rd != 5'd0) &&
                    ((ex_rd == id_rs1) || (ex_rd == id_rs2));

endmodule

// File: rtl/pc_ctrl.sv
// Front-end sequencer: chooses next_PC and drives pipeline stall/flush controls
// for boot, EX redirects, load-use hazards, I-cache refills and D-memory freezes.
module pc_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PC_F,
  input  logic        ex_redirect,
  input  logic [31:0] ex_target,
  input  logic        ex_memread,
  input  logic [4:0]  ex_rd,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        icache_miss,
  input  logic        refill_done,
  input  logic        dmem_busy,
  output logic [31:0] next_PC,
  output logic        stall_F,
  output logic        stall_D,
  output logic        stall_back,
  output logic        flush_D,
  output logic        flush_E,
  output logic [31:0] stall_cycles
);

  pc_state_t   state_q, state_d;
  logic        pend_valid_q, pend_valid_d;
  logic [31:0] pend_target_q, pend_target_d;
  logic [31:0] stall_cycles_q;
  logic        load_use;
  logic        redir_now;
  logic [31:0] pc_seq;

  hazard_detect u_hazard (
    .ex_memread (ex_memread),
    .ex_rd      (ex_rd),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .load_use   (load_use)
  );

  assign pc_seq    = PC_F + PC_INCR;
  assign redir_now = ex_redirect && !dmem_busy;

  always_comb begin
    next_PC       = pc_seq;
    stall_F       = 1'b0;
    stall_D       = 1'b0;
    stall_back    = 1'b0;
    flush_D       = 1'b0;
    flush_E       = 1'b0;
    state_d       = state_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;

    if (!rst) begin
      next_PC = RESET_VECTOR;
      flush_D = 1'b1;
      flush_E = 1'b1;
    end else begin
      case (state_q)
        ST_BOOT: begin
          next_PC = RESET_VECTOR;
          flush_D = 1'b1;
          flush_E = 1'b1;
          state_d = ST_RUN;
        end

        ST_RUN: begin
          if (dmem_busy) begin
            stall_F    = 1'b1;
            stall_D    = 1'b1;
            stall_back = 1'b1;
          end else if (ex_redirect) begin
            next_PC = ex_target;
            flush_D = 1'b1;
            flush_E = 1'b1;
          end else if (load_use) begin
            stall_F = 1'b1;
            stall_D = 1'b1;
            flush_E = 1'b1;
          end else if (icache_miss) begin
            stall_F = 1'b1;
            flush_D = 1'b1;
            state_d = ST_IMISS;
          end
        end

        ST_IMISS: begin
          stall_F = 1'b1;
          flush_D = 1'b1;
          // Redirects arriving during a refill are parked until the refill lands.
          if (redir_now) begin
            pend_valid_d  = 1'b1;
            pend_target_d = ex_target;
            flush_E       = 1'b1;
          end
          if (dmem_busy) begin
            stall_D    = 1'b1;
            stall_back = 1'b1;
            flush_D    = 1'b0;
          end
          // A redirect landing in the refill cycle itself is taken directly.
          if (refill_done) begin
            state_d      = ST_RUN;
            pend_valid_d = 1'b0;
            stall_F      = dmem_busy;
            if (redir_now) begin
              next_PC = ex_target;
              flush_D = 1'b1;
            end else if (pend_valid_q) begin
              next_PC = pend_target_q;
              flush_D = 1'b1;
            end else begin
              next_PC = pc_seq;
              flush_D = 1'b0;
            end
          end
        end

        default: begin
          next_PC = RESET_VECTOR;
          flush_D = 1'b1;
          flush_E = 1'b1;
          state_d = ST_BOOT;
        end
      endcase

      if (stall_F) next_PC = PC_F;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= ST_BOOT;
      pend_valid_q   <= 1'b0;
      stall_cycles_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      pend_valid_q <= pend_valid_d;
      if (stall_F) stall_cycles_q <= sat_inc32(stall_cycles_q);
    end
  end

  // Pending target is qualified by pend_valid, so it carries no reset.
  always_ff @(posedge clk) begin
    pend_target_q <= pend_target_d;
  end

  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pc_ctrl.sv
// Directed bench for pc_ctrl with a behavioural reference checked every cycle.
module tb_pc_ctrl;

  localparam logic [31:0] RV = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PC_F;
  logic        ex_redirect;
  logic [31:0] ex_target;
  logic        ex_memread;
  logic [4:0]  ex_rd, id_rs1, id_rs2;
  logic        icache_miss, refill_done, dmem_busy;
  logic [31:0] next_PC;
  logic        stall_F, stall_D, stall_back, flush_D, flush_E;
  logic [31:0] stall_cycles;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pc_ctrl #(.RESET_VECTOR(RV)) dut (
    .clk(clk), .rst(rst), .PC_F(PC_F),
    .ex_redirect(ex_redirect), .ex_target(ex_target),
    .ex_memread(ex_memread), .ex_rd(ex_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .icache_miss(icache_miss), .refill_done(refill_done), .dmem_busy(dmem_busy),
    .next_PC(next_PC), .stall_F(stall_F), .stall_D(stall_D), .stall_back(stall_back),
    .flush_D(flush_D), .flush_E(flush_E), .stall_cycles(stall_cycles)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: mode 0 = not yet reset, 1 = boot, 2 = running, 3 = waiting on refill
  int          m_mode = 0, nx_mode = 0;
  bit          m_pend = 0, nx_pend = 0;
  logic [31:0] m_ptgt = '0, nx_ptgt = '0;
  longint      m_cnt = 0, nx_cnt = 0;

  always @(negedge clk) begin
    logic [31:0] e_npc;
    bit e_sF, e_sD, e_sB, e_fD, e_fE, hz, take;
    int n_mode; bit n_pend; logic [31:0] n_ptgt; longint n_cnt;
    hz = ex_memread && (ex_rd != 0) && (ex_rd == id_rs1 || ex_rd == id_rs2);
    e_npc = PC_F + 32'd4;
    {e_sF, e_sD, e_sB, e_fD, e_fE} = '0;
    n_mode = m_mode; n_pend = m_pend; n_ptgt = m_ptgt; n_cnt = m_cnt;
    if (rst !== 1'b1) begin
      e_npc = RV; e_fD = 1; e_fE = 1;
      n_mode = 1; n_pend = 0; n_cnt = 0;
    end else if (m_mode == 1) begin
      e_npc = RV; e_fD = 1; e_fE = 1; n_mode = 2;
    end else if (m_mode == 2) begin
      if (dmem_busy) begin e_sF = 1; e_sD = 1; e_sB = 1; end
      else if (ex_redirect) begin e_npc = ex_target; e_fD = 1; e_fE = 1; end
      else if (hz) begin e_sF = 1; e_sD = 1; e_fE = 1; end
      else if (icache_miss) begin e_sF = 1; e_fD = 1; n_mode = 3; end
    end else if (m_mode == 3) begin
      e_sF = 1; e_fD = 1;
      take = ex_redirect && !dmem_busy;
      if (take) begin n_pend = 1; n_ptgt = ex_target; e_fE = 1; end
      if (dmem_busy) begin e_sD = 1; e_sB = 1; e_fD = 0; end
      if (refill_done) begin
        n_mode = 2; n_pend = 0; e_sF = dmem_busy;
        if (take) begin e_npc = ex_target; e_fD = 1; end
        else if (m_pend) begin e_npc = m_ptgt; e_fD = 1; end
        else begin e_npc = PC_F + 32'd4; e_fD = 0; end
      end
    end
    if (e_sF) e_npc = PC_F;
    if (rst === 1'b1 && e_sF && m_mode != 0 && m_cnt < 64'hFFFF_FFFF) n_cnt = m_cnt + 1;
    if (m_mode != 0 || rst !== 1'b1) begin
      check("model next_PC", next_PC, e_npc);
      check("model stall_F", {31'd0, stall_F}, {31'd0, e_sF});
      check("model stall_D", {31'd0, stall_D}, {31'd0, e_sD});
      check("model stall_back", {31'd0, stall_back}, {31'd0, e_sB});
      check("model flush_D", {31'd0, flush_D}, {31'd0, e_fD});
      check("model flush_E", {31'd0, flush_E}, {31'd0, e_fE});
    end
    if (m_mode != 0) check("model stall_cycles", stall_cycles, m_cnt[31:0]);
    nx_mode <= n_mode; nx_pend <= n_pend; nx_ptgt <= n_ptgt; nx_cnt <= n_cnt;
  end

  always @(posedge clk) begin
    m_mode <= nx_mode; m_pend <= nx_pend; m_ptgt <= nx_ptgt; m_cnt <= nx_cnt;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    ex_redirect = 0; ex_target = '0; ex_memread = 0; ex_rd = '0;
    id_rs1 = '0; id_rs2 = '0; icache_miss = 0; refill_done = 0; dmem_busy = 0;
  endtask

  task automatic vec(input string tag, input logic [31:0] npc,
                     input bit sF, input bit sD, input bit sB, input bit fD, input bit fE);
    #3;
    check({tag, " next_PC"}, next_PC, npc);
    check({tag, " stalls/flushes"}, {27'd0, stall_F, stall_D, stall_back, flush_D, flush_E},
          {27'd0, sF, sD, sB, fD, fE});
  endtask

  task automatic cnt(input string tag, input logic [31:0] v);
    check({tag, " stall_cycles"}, stall_cycles, v);
  endtask

  initial begin
    rst = 0; PC_F = '0; clr();
    cyc(); vec("reset0", RV, 0, 0, 0, 1, 1);
    cyc(); vec("reset1", RV, 0, 0, 0, 1, 1);
    rst = 1; vec("boot", RV, 0, 0, 0, 1, 1); cnt("boot", 0);
    cyc(); PC_F = 32'h0; vec("run0", 32'h4, 0, 0, 0, 0, 0); cnt("run0", 0);
    // load-use, then the same pattern with x0 as destination
    cyc(); PC_F = 32'h10; ex_memread = 1; ex_rd = 5; id_rs2 = 5;
    vec("loaduse", 32'h10, 1, 1, 0, 0, 1);
    cyc(); ex_rd = 0; id_rs2 = 0; vec("x0 load", 32'h14, 0, 0, 0, 0, 0); cnt("x0 load", 1);
    cyc(); PC_F = 32'h18; ex_rd = 5; id_rs1 = 5; ex_redirect = 1; ex_target = 32'h100;
    vec("redir+lu", 32'h100, 0, 0, 0, 1, 1);
    // I-miss with redirect buffered in the 2nd refill cycle
    cyc(); clr(); PC_F = 32'h40; icache_miss = 1; vec("miss", 32'h40, 1, 0, 0, 1, 0); cnt("miss", 1);
    cyc(); clr(); vec("imiss1", 32'h40, 1, 0, 0, 1, 0); cnt("imiss1", 2);
    cyc(); ex_redirect = 1; ex_target = 32'h200; vec("imiss2", 32'h40, 1, 0, 0, 1, 1);
    cyc(); clr(); refill_done = 1; vec("refill", 32'h200, 0, 0, 0, 1, 0); cnt("refill", 4);
    cyc(); clr(); PC_F = 32'h200; vec("post refill", 32'h204, 0, 0, 0, 0, 0); cnt("post refill", 4);
    // D-memory freeze with a redirect held across it
    for (int i = 0; i < 4; i++) begin
      cyc(); PC_F = 32'h204; dmem_busy = 1; ex_redirect = 1; ex_target = 32'h300;
      vec("dfreeze", 32'h204, 1, 1, 1, 0, 0); cnt("dfreeze", 4 + i);
    end
    cyc(); dmem_busy = 0; vec("unfreeze", 32'h300, 0, 0, 0, 1, 1); cnt("unfreeze", 8);
    cyc(); clr(); PC_F = 32'h300; refill_done = 1; vec("stray refill", 32'h304, 0, 0, 0, 0, 0);
    cyc(); clr(); PC_F = 32'hFFFF_FFFC; vec("wrap", 32'h0, 0, 0, 0, 0, 0);
    // reset while a redirect is pending inside a refill
    cyc(); PC_F = 32'h80; icache_miss = 1; vec("miss2", 32'h80, 1, 0, 0, 1, 0); cnt("miss2", 8);
    cyc(); clr(); dmem_busy = 1; ex_redirect = 1; ex_target = 32'hBAD0;
    vec("imiss busy", 32'h80, 1, 1, 1, 0, 0); cnt("imiss busy", 9);
    cyc(); dmem_busy = 0; ex_target = 32'h400; vec("imiss redir", 32'h80, 1, 0, 0, 1, 1);
    cyc(); clr(); rst = 0; vec("mid reset", RV, 0, 0, 0, 1, 1); cnt("mid reset", 11);
    cyc(); rst = 1; vec("reboot", RV, 0, 0, 0, 1, 1); cnt("reboot", 0);
    cyc(); PC_F = 32'h0; icache_miss = 1; vec("miss3", 32'h0, 1, 0, 0, 1, 0);
    cyc(); clr(); refill_done = 1; vec("refill nopend", 32'h4, 0, 0, 0, 0, 0); cnt("refill nopend", 1);
    // load-use held across a freeze reasserts once the freeze ends
    cyc(); clr(); PC_F = 32'h8; ex_memread = 1; ex_rd = 7; id_rs1 = 7; dmem_busy = 1;
    vec("lu frozen", 32'h8, 1, 1, 1, 0, 0);
    cyc(); dmem_busy = 0; vec("lu after", 32'h8, 1, 1, 0, 0, 1); cnt("lu after", 2);
    cyc(); clr(); vec("resume", 32'hC, 0, 0, 0, 0, 0); cnt("resume", 3);
    cyc();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pc_ctrl.md
# pc_ctrl

Front-end sequencing controller for the pipelined RISC-V core. It selects `next_PC` for the PC register and generates the pipeline stall and flush controls. It covers post-reset boot, EX-stage redirects, load-use hazards, instruction-cache misses (including redirects buffered during a refill) and data-memory freezes. It sits between the hazard sources (ID/EX/MEM, caches) and the PC/pipeline registers, and drives their `stall_in` and flush inputs.

## Interface
- `RESET_VECTOR`, 32'h0000_0000, PC loaded at boot.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `PC_F`  in  32  current fetch PC (PC register output).
- `ex_redirect`  in  1  taken branch/jump resolved in EX.
- `ex_target`  in  32  redirect target; valid with `ex_redirect`.
- `ex_memread`  in  1  EX instruction is a load.
- `ex_rd`  in  5  EX destination register.
- `id_rs1`, `id_rs2`  in  5 each  ID source registers.
- `icache_miss`  in  1  fetch at `PC_F` missed this cycle.
- `refill_done`  in  1  one-cycle pulse: refill complete, instruction at `PC_F` presented this cycle.
- `dmem_busy`  in  1  data memory not ready; back end must freeze.
- `next_PC`  out  32  value for the PC register to load.
- `stall_F`  out  1  hold PC register (drives `stall_in`).
- `stall_D`  out  1  hold IF/ID register.
- `stall_back`  out  1  hold ID/EX, EX/MEM and MEM/WB.
- `flush_D`  out  1  insert bubble into IF/ID.
- `flush_E`  out  1  insert bubble into ID/EX.
- `stall_cycles`  out  32  saturating front-end stall counter.

## Operation
- States are BOOT, RUN and IMISS. Registered state: the state itself, `pend_valid`, `pend_target[31:0]` and `stall_cycles`. All other outputs are combinational.
- Reset:
  - While `rst`=0, outputs are forced: `next_PC`=RESET_VECTOR, `flush_D`=`flush_E`=1, all stalls 0.
  - On the clock edge with `rst`=0: state becomes BOOT; `pend_valid` and `stall_cycles` clear.
  - This applies from any state, including mid-IMISS; a pending redirect is discarded.
- BOOT lasts one cycle:
  - `next_PC`=RESET_VECTOR, `flush_D`=`flush_E`=1, stalls 0.
  - Always transitions to RUN.
- RUN, evaluated in priority order:
  1. `dmem_busy`: `stall_F`=`stall_D`=`stall_back`=1, no flushes. Redirect, hazard and miss inputs are ignored (they are re-evaluated when the freeze ends). Stay in RUN.
  2. `ex_redirect`: `next_PC`=`ex_target`, `flush_D`=`flush_E`=1, `stall_F`=0. This overrides load-use and miss.
  3. Load-use: condition is `ex_memread` && `ex_rd`!=0 && (`ex_rd`==`id_rs1` || `ex_rd`==`id_rs2`). Response: `stall_F`=`stall_D`=1 and `flush_E`=1 for that cycle.
  4. `icache_miss`: `stall_F`=1, `flush_D`=1. Go to IMISS.
  5. Otherwise: `next_PC`=`PC_F`+4 (32-bit wrap), no stalls or flushes.
- IMISS:
  - Default: `stall_F`=1, `flush_D`=1.
  - `ex_redirect` while `!dmem_busy`: set `pend_valid`=1, `pend_target`=`ex_target`, and `flush_E`=1. A later redirect overwrites the pending one.
  - `dmem_busy`: `stall_D`=`stall_back`=1, `flush_D`=0; redirect is not sampled.
  - `refill_done`: go to RUN and clear `pend_valid`.
    - If `pend_valid`: `next_PC`=`pend_target`, `flush_D`=1.
    - Otherwise: `next_PC`=`PC_F`+4, `flush_D`=0.
    - `stall_F`=`dmem_busy`.
  - `refill_done` is honoured even during `dmem_busy`.
- `stall_cycles` increments on every edge where `stall_F`=1 in RUN or IMISS. It saturates at 32'hFFFF_FFFF.
- While `stall_F`=1, `next_PC`=`PC_F`.

## Timing
- All decisions are combinational in the same cycle as the inputs; zero latency to the stall/flush outputs.
- State, pending-redirect and counter updates take effect at the next rising edge.
- Load-use stall lasts exactly one cycle per hazard. It reasserts if the condition persists, for example when `dmem_busy` freezes EX.
- IMISS minimum residency is 1 cycle, when `refill_done` arrives in the first IMISS cycle.
- `refill_done` outside IMISS is ignored.

## Structure
- `pc_ctrl_pkg`: state enum (BOOT, RUN, IMISS), the `PC_INCR`=4 constant and the `RESET_VECTOR` default.
- Sub-module `hazard_detect`: combinational load-use comparator taking `ex_memread`, `ex_rd`, `id_rs1` and `id_rs2`, producing `load_use`.

## Test plan
- **Reset release:** hold `rst`=0 for 2 cycles, then set `rst`=1.
  - First cycle: BOOT, `next_PC`=0, `flush_D`=`flush_E`=1.
  - Next cycle: RUN with `PC_F`=0, so `next_PC`=4.
- **Load-use:** `ex_memread`=1, `ex_rd`=5, `id_rs2`=5 → `stall_F`=`stall_D`=`flush_E`=1 for one cycle. Repeating with `ex_rd`=0 → no stall.
- **Redirect + load-use, same cycle:** `ex_target`=0x100 → `next_PC`=0x100, `flush_D`=`flush_E`=1, `stall_F`=0, `stall_D`=0.
- **I-miss with buffered redirect:** `icache_miss` at `PC_F`=0x40, redirect to 0x200 in the 2nd IMISS cycle, `refill_done` in the 3rd.
  - `stall_F`=1 throughout.
  - On `refill_done`: `next_PC`=0x200, `flush_D`=1.
  - `stall_cycles` increases by 3 overall.
- **D-freeze:** `dmem_busy` for 4 cycles with `ex_redirect` (target 0x300) held.
  - All stalls asserted, no flushes.
  - Cycle after busy drops: `next_PC`=0x300, `flush_D`=`flush_E`=1.
- **Reset mid-operation:** `rst`=0 during IMISS with `pend_valid`=1 → next cycle BOOT, `pend_valid`=0, `stall_cycles`=0, `next_PC`=RESET_VECTOR.
